// File: rtl/ps2_tx.sv
// ps2_tx - PS/2 host-to-device transmitter.
//
// Sends one command/parameter byte to a PS/2 device using the host request
// sequence: inhibit the clock, present the start bit, release the clock, then
// shift data, odd parity and stop on device clock falling edges. The device
// acknowledge is checked on the eleventh clock. The block reports `done` on
// ACK and `error` on NACK or timeout. While a transfer runs, `busy` tells the
// keyboard receiver to ignore the bus.
//
// Ports:
//   clk28       in   system clock (only clock in this block)
//   rst         in   synchronous active-high reset
//   tx_data     in   [7:0] byte to send, sampled when tx_valid && tx_ready
//   tx_valid    in   send request, held by the requester until accepted
//   tx_ready    out  idle; a request is accepted this cycle
//   done        out  one-cycle pulse: transfer acknowledged
//   error       out  one-cycle pulse: timeout or NACK
//   busy        out  transfer in progress (receiver inhibit)
//   ps2_clk_in  in   raw PS/2 clock pin level
//   ps2_dat_in  in   raw PS/2 data pin level
//   ps2_clk_oe  out  1 pulls the clock pin low, 0 releases it
//   ps2_dat_oe  out  1 pulls the data pin low, 0 releases it
module ps2_tx #(
    parameter int unsigned CLK_FREQ       = 32'd28_000_000,
    parameter int unsigned INHIBIT_US     = 32'd120,
    parameter int unsigned REQ_TIMEOUT_US = 32'd15000,
    parameter int unsigned PKT_TIMEOUT_US = 32'd2000
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned CYC_PER_US = CLK_FREQ / 32'd1_000_000;

    // The shared counter is loaded with N-1 and a state acts when it reads
    // zero, so the transition lands exactly N cycles after the load.
    localparam logic [18:0] INH_LOAD   = 19'(CYC_PER_US * INHIBIT_US - 32'd1);
    localparam logic [18:0] START_LOAD = 19'd27;
    localparam logic [18:0] RTO_LOAD   = 19'(CYC_PER_US * REQ_TIMEOUT_US - 32'd1);
    localparam logic [18:0] PTO_LOAD   = 19'(CYC_PER_US * PKT_TIMEOUT_US - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CLK  = 3'd3,
        S_BITS      = 3'd4,
        S_ACK       = 3'd5,
        S_WAIT_IDLE = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    // Odd parity bit for a data byte.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // One step of the stability filter: returns {new level, new run count}.
    // The level follows the sample only after 8 consecutive differing samples.
    function automatic logic [3:0] filt_step(input logic smp, input logic filt,
                                             input logic [2:0] cnt);
        logic [3:0] r;
        if (smp == filt) begin
            r = {filt, 3'd0};
        end else if (cnt == 3'd7) begin
            r = {smp, 3'd0};
        end else begin
            r = {filt, cnt + 3'd1};
        end
        return r;
    endfunction

    // Input conditioning
    logic [1:0] clk_sync_r, dat_sync_r;
    logic [2:0] clk_cnt_r, dat_cnt_r;
    logic       clk_filt_r, dat_filt_r, clk_filt_d_r, fall_r;

    // FSM state and datapath
    state_t      state_r, state_s;
    logic [18:0] cnt_r, cnt_s;
    logic [3:0]  idx_r, idx_s;
    logic [7:0]  data_r, data_s;
    logic        par_r, par_s;
    logic        clk_oe_r, clk_oe_s, dat_oe_r, dat_oe_s;
    logic        done_r, done_s, error_r, error_s;
    logic        ready_r, ready_s, busy_r, busy_s;
    logic        expire_s;

    // Synchronize and filter both pins; register the filtered clock falling edge.
    always_ff @(posedge clk28) begin
        if (rst) begin
            clk_sync_r   <= 2'b11;
            dat_sync_r   <= 2'b11;
            clk_cnt_r    <= 3'd0;
            dat_cnt_r    <= 3'd0;
            clk_filt_r   <= 1'b1;
            dat_filt_r   <= 1'b1;
            clk_filt_d_r <= 1'b1;
            fall_r       <= 1'b0;
        end else begin
            clk_sync_r   <= {clk_sync_r[0], ps2_clk_in};
            dat_sync_r   <= {dat_sync_r[0], ps2_dat_in};
            {clk_filt_r, clk_cnt_r} <= filt_step(clk_sync_r[1], clk_filt_r, clk_cnt_r);
            {dat_filt_r, dat_cnt_r} <= filt_step(dat_sync_r[1], dat_filt_r, dat_cnt_r);
            clk_filt_d_r <= clk_filt_r;
            fall_r       <= clk_filt_d_r & ~clk_filt_r;
        end
    end

    assign expire_s = (cnt_r == 19'd0);

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        data_s   = data_r;
        par_s    = par_r;
        clk_oe_s = clk_oe_r;
        dat_oe_s = dat_oe_r;
        done_s   = 1'b0;
        error_s  = 1'b0;
        if (cnt_r != 19'd0) begin
            cnt_s = cnt_r - 19'd1;
        end else begin
            cnt_s = cnt_r;
        end

        case (state_r)
            S_IDLE: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
                if (tx_valid && ready_r) begin
                    data_s   = tx_data;
                    par_s    = odd_parity(tx_data);
                    idx_s    = 4'd0;
                    cnt_s    = INH_LOAD;
                    clk_oe_s = 1'b1;
                    state_s  = S_INHIBIT;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_INHIBIT: begin
                clk_oe_s = 1'b1;
                if (expire_s) begin
                    dat_oe_s = 1'b1;
                    cnt_s    = START_LOAD;
                    state_s  = S_START;
                end else begin
                    state_s  = S_INHIBIT;
                end
            end
            S_START: begin
                if (expire_s) begin
                    clk_oe_s = 1'b0;
                    cnt_s    = RTO_LOAD;
                    state_s  = S_WAIT_CLK;
                end else begin
                    state_s  = S_START;
                end
            end
            S_WAIT_CLK: begin
                if (fall_r) begin
                    dat_oe_s = ~data_r[0];
                    cnt_s    = PTO_LOAD;
                    idx_s    = 4'd1;
                    state_s  = S_BITS;
                end else if (expire_s) begin
                    dat_oe_s = 1'b0;
                    error_s  = 1'b1;
                    state_s  = S_ERR;
                end else begin
                    state_s  = S_WAIT_CLK;
                end
            end
            S_BITS: begin
                if (fall_r) begin
                    case (idx_r)
                        4'd1, 4'd2, 4'd3, 4'd4,
                        4'd5, 4'd6, 4'd7: dat_oe_s = ~data_r[idx_r[2:0]];
                        4'd8:             dat_oe_s = ~par_r;
                        default:          dat_oe_s = 1'b0;    // stop bit: line released
                    endcase
                    idx_s = idx_r + 4'd1;
                    if (idx_r == 4'd9) begin
                        state_s = S_ACK;
                    end else begin
                        state_s = S_BITS;
                    end
                end else if (expire_s) begin
                    dat_oe_s = 1'b0;
                    error_s  = 1'b1;
                    state_s  = S_ERR;
                end else begin
                    state_s  = S_BITS;
                end
            end
            S_ACK: begin
                dat_oe_s = 1'b0;
                if (fall_r) begin
                    if (!dat_filt_r) begin
                        state_s = S_WAIT_IDLE;
                    end else begin
                        error_s = 1'b1;
                        state_s = S_ERR;
                    end
                end else if (expire_s) begin
                    error_s = 1'b1;
                    state_s = S_ERR;
                end else begin
                    state_s = S_ACK;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_filt_r && dat_filt_r) begin
                    done_s  = 1'b1;
                    state_s = S_IDLE;
                end else if (expire_s) begin
                    error_s = 1'b1;
                    state_s = S_ERR;
                end else begin
                    state_s = S_WAIT_IDLE;
                end
            end
            S_ERR: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
                state_s  = S_IDLE;
            end
            default: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
                state_s  = S_IDLE;
            end
        endcase

        // Ready stays low in the cycle done pulses so a waiting request is
        // taken one cycle later; the error pulse is the ERR cycle itself.
        ready_s = (state_s == S_IDLE) && !done_s;
        busy_s  = ~ready_s;
    end

    // FSM and output registers.
    always_ff @(posedge clk28) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= 19'd0;
            idx_r    <= 4'd0;
            data_r   <= 8'd0;
            par_r    <= 1'b0;
            clk_oe_r <= 1'b0;
            dat_oe_r <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            data_r   <= data_s;
            par_r    <= par_s;
            clk_oe_r <= clk_oe_s;
            dat_oe_r <= dat_oe_s;
            done_r   <= done_s;
            error_r  <= error_s;
            ready_r  <= ready_s;
            busy_r   <= busy_s;
        end
    end

    assign ps2_clk_oe = clk_oe_r;
    assign ps2_dat_oe = dat_oe_r;
    assign done       = done_r;
    assign error      = error_r;
    assign tx_ready   = ready_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx - directed self-checking bench for ps2_tx.
// A behavioural PS/2 device clocks frames out of the host, samples each bit
// on the rising clock edge, and answers ACK or NACK on clock 11.
module tb_ps2_tx;

    // Request timeout shortened so the no-clock case stays short.
    localparam int unsigned CLK_FREQ       = 28_000_000;
    localparam int unsigned INHIBIT_US     = 120;
    localparam int unsigned REQ_TIMEOUT_US = 200;
    localparam int unsigned PKT_TIMEOUT_US = 2000;

    localparam int INH_CYC   = 3360;   // 28 cycles/us * 120 us
    localparam int HOLD_CYC  = 3388;   // inhibit + 28-cycle start phase
    localparam int RTO_CYC   = 5600;   // 28 cycles/us * 200 us
    localparam int HALF_SLOW = 1120;   // 12.5 kHz device clock half-period
    localparam int HALF_FAST = 150;

    logic       clk28 = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, done, error, busy;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low, dev_dat_low;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_tx #(
        .CLK_FREQ       (CLK_FREQ),
        .INHIBIT_US     (INHIBIT_US),
        .REQ_TIMEOUT_US (REQ_TIMEOUT_US),
        .PKT_TIMEOUT_US (PKT_TIMEOUT_US)
    ) dut (
        .clk28      (clk28),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .done       (done),
        .error      (error),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk28 = ~clk28;

    // Count status pulses away from the active edge.
    always @(negedge clk28) begin
        if (done)          done_cnt <= done_cnt + 1;
        if (error)         err_cnt  <= err_cnt + 1;
        if (done && error) both_cnt <= both_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk28);
    endtask

    // Present a byte and let the next ready cycle take it.
    task automatic request(input logic [7:0] b, input bit keep);
        int t = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && t < 100) begin
            tick(1);
            t++;
        end
        check_eq("ready_wait", 32'(tx_ready), 32'd1);
        tick(1);
        if (!keep) tx_valid = 1'b0;
        check_eq("accept_clk_oe", 32'({ps2_clk_oe, tx_ready, busy}), 32'b101);
    endtask

    // Length of the clock inhibit, and when the start bit appears within it.
    task automatic measure_hold(output int hold, output int dly);
        hold = 0;
        dly  = -1;
        while (ps2_clk_oe && hold < 5000) begin
            hold++;
            if (ps2_dat_oe && dly < 0) dly = hold - 1;
            tick(1);
        end
    endtask

    // Device side of one frame: clocks 1..last_clk, samples on rising edges.
    task automatic dev_frame(input int half, input bit ack, input bit glitch,
                             input int last_clk, output logic [9:0] bits);
        bits = 10'd0;
        for (int k = 1; k <= last_clk; k++) begin
            if (k == 11 && ack) dev_dat_low = 1'b1;
            if (glitch && k >= 3 && k <= 8) begin
                tick(half / 2);
                dev_clk_low = 1'b1;
                tick(5);
                dev_clk_low = 1'b0;
                tick(half - half / 2 - 5);
            end else begin
                tick(half);
            end
            dev_clk_low = 1'b1;
            tick(half);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = ps2_dat_in;
        end
        tick(20);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        int t = 0;
        while (!(done || error) && done_cnt == d0 && err_cnt == e0 && t < 1000) begin
            tick(1);
            t++;
        end
    endtask

    initial begin
        int         hold, dly, d0, e0, t;
        logic [9:0] bits;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        tick(3);
        check_eq("reset_outs", 32'({tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe}), 32'd0);
        rst = 1'b0;
        tick(1);
        check_eq("ready_after_rst", 32'({tx_ready, busy}), 32'b10);

        // 0xED at 12.5 kHz with ACK
        d0 = done_cnt; e0 = err_cnt;
        request(8'hED, 1'b0);
        measure_hold(hold, dly);
        check_eq("clk_oe_hold", hold, HOLD_CYC);
        check_eq("dat_oe_delay", dly, INH_CYC);
        check_eq("start_bit_on_release", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
        dev_frame(HALF_SLOW, 1'b1, 1'b0, 11, bits);
        check_eq("ed_bits", 32'(bits), 32'h3ED);
        wait_end(d0, e0);
        tick(2);
        check_eq("ed_done", done_cnt - d0, 1);
        check_eq("ed_error", err_cnt - e0, 0);
        check_eq("ed_idle", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready}), 32'b001);

        // 0x00 with tx_valid held throughout, then 0x01 with clock glitches
        d0 = done_cnt; e0 = err_cnt;
        request(8'h00, 1'b1);
        measure_hold(hold, dly);
        dev_frame(HALF_FAST, 1'b1, 1'b0, 11, bits);
        check_eq("x00_bits", 32'(bits), 32'h300);
        wait_end(d0, e0);
        check_eq("done_cycle", 32'({done, tx_ready, busy}), 32'b101);
        tx_data = 8'h01;
        tick(1);
        check_eq("no_accept_on_done", 32'({tx_ready, ps2_clk_oe}), 32'b10);
        request(8'h01, 1'b0);
        measure_hold(hold, dly);
        check_eq("x01_hold", hold, HOLD_CYC);
        dev_frame(HALF_FAST, 1'b1, 1'b1, 11, bits);
        check_eq("x01_glitch_bits", 32'(bits), 32'h201);
        wait_end(d0 + 1, e0);
        tick(2);
        check_eq("x00_x01_done", done_cnt - d0, 2);
        check_eq("x00_x01_error", err_cnt - e0, 0);

        // NACK on clock 11
        d0 = done_cnt; e0 = err_cnt;
        request(8'hA5, 1'b0);
        measure_hold(hold, dly);
        dev_frame(HALF_FAST, 1'b0, 1'b0, 11, bits);
        check_eq("a5_bits", 32'(bits), 32'h3A5);
        wait_end(d0, e0);
        tick(2);
        check_eq("nack_done", done_cnt - d0, 0);
        check_eq("nack_error", err_cnt - e0, 1);
        check_eq("nack_lines", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready}), 32'b001);

        // Device never clocks
        d0 = done_cnt; e0 = err_cnt;
        request(8'h3C, 1'b0);
        measure_hold(hold, dly);
        t = 0;
        while (!error && t < RTO_CYC + 100) begin
            tick(1);
            t++;
        end
        check_eq("rto_cycles", t, RTO_CYC);
        check_eq("rto_lines", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready}), 32'b000);
        tick(1);
        check_eq("rto_ready", 32'(tx_ready), 32'd1);
        tick(1);
        check_eq("rto_error", err_cnt - e0, 1);
        check_eq("rto_done", done_cnt - d0, 0);

        // Reset with bit index 4
        d0 = done_cnt; e0 = err_cnt;
        request(8'h55, 1'b0);
        measure_hold(hold, dly);
        dev_frame(HALF_FAST, 1'b1, 1'b0, 4, bits);
        check_eq("x55_low_bits", 32'(bits[3:0]), 32'h5);
        check_eq("pre_rst_dat_oe", 32'(ps2_dat_oe), 32'd1);
        rst = 1'b1;
        tick(1);
        check_eq("rst_mid_outs", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, busy}), 32'd0);
        rst = 1'b0;
        tick(1);
        check_eq("rst_mid_ready", 32'({tx_ready, busy}), 32'b10);

        // 0xFF after the reset
        request(8'hFF, 1'b0);
        measure_hold(hold, dly);
        check_eq("ff_hold", hold, HOLD_CYC);
        dev_frame(HALF_FAST, 1'b1, 1'b0, 11, bits);
        check_eq("ff_bits", 32'(bits), 32'h3FF);
        wait_end(d0, e0);
        tick(2);
        check_eq("ff_done", done_cnt - d0, 1);
        check_eq("ff_error", err_cnt - e0, 0);

        tick(5);
        check_eq("done_error_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
